sd_det_debounce: RTL and testbench

- Upstream conditioning stage for the SD card-detect PIO.
- Takes the raw asynchronous SD socket pins: card-detect (CD, active-low) and write-protect (WP).
- Synchronises each pin, debounces it with a per-bit qualification counter, and drives a clean 2-bit level that feeds the PIO input port directly.
- Also produces single-cycle insertion/removal/change event pulses for interrupt or status logic.

---
 rtl/sd_det_debounce.sv | 137 +++++++++++++
 tb/tb_sd_det_debounce.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sd_det_debounce.sv
// SD socket card-detect / write-protect conditioner: 2-flop sync, per-bit debounce FSM, event pulses.
// Optional glitch (aborted qualification) counter enabled by defining SD_DET_GLITCH_CNT_EN.
module sd_det_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter logic [1:0]  RESET_VAL       = 2'b11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] pin_in,
  output logic [1:0] stable_out,
  output logic [1:0] change_pulse,
  output logic       card_present,
  output logic       card_inserted,
  output logic       card_removed,
  output logic [7:0] glitch_count,
  input  logic       glitch_clr
);

  if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > (2 ** CNT_W) - 1)) begin : g_bad_cfg
    $error("sd_det_debounce: DEBOUNCE_CYCLES=%0d outside 2..2^CNT_W-1", DEBOUNCE_CYCLES);
  end

  typedef enum logic {
    IDLE    = 1'b0,
    QUALIFY = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Valid/ready does not apply here: every output is a level or a one-cycle pulse, no back-pressure.
  state_e           state_q [2];
  state_e           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       stable_q, stable_d;
  logic [1:0]       change_q, change_d;
  logic [1:0]       abort;
  logic             inserted_q, removed_q;

  always_comb begin
    stable_d = stable_q;
    change_d = '0;
    abort    = '0;
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      if (state_q[b] == IDLE) begin
        cnt_d[b] = '0;
        if (sync2_q[b] != stable_q[b]) begin
          state_d[b] = QUALIFY;
          cnt_d[b]   = CNT_W'(1);
        end
      end else begin
        if (sync2_q[b] == stable_q[b]) begin
          state_d[b] = IDLE;
          cnt_d[b]   = '0;
          abort[b]   = 1'b1;
        end else if (cnt_q[b] == CNT_TERM) begin
          // Terminal compare ends qualification, so the counter can never wrap.
          state_d[b]  = IDLE;
          cnt_d[b]    = '0;
          stable_d[b] = sync2_q[b];
          change_d[b] = 1'b1;
        end else begin
          cnt_d[b] = cnt_q[b] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= RESET_VAL;
      sync2_q    <= RESET_VAL;
      stable_q   <= RESET_VAL;
      change_q   <= '0;
      inserted_q <= 1'b0;
      removed_q  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= IDLE;
        cnt_q[b]   <= '0;
      end
    end else begin
      sync1_q    <= pin_in;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      change_q   <= change_d;
      inserted_q <= change_d[0] & ~stable_d[0];
      removed_q  <= change_d[0] & stable_d[0];
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
    end
  end

  assign stable_out    = stable_q;
  assign change_pulse  = change_q;
  assign card_present  = ~stable_q[0];
  assign card_inserted = inserted_q;
  assign card_removed  = removed_q;

`ifdef SD_DET_GLITCH_CNT_EN
  logic [7:0] glitch_q, glitch_d;
  logic [8:0] glitch_sum;

  // Clear beats a same-edge abort; both bits aborting together add 2.
  always_comb begin
    glitch_sum = {1'b0, glitch_q} + 9'(abort[0]) + 9'(abort[1]);
    glitch_d   = glitch_q;
    if (glitch_clr) begin
      glitch_d = '0;
    end else if (glitch_sum[8]) begin
      glitch_d = 8'hff;
    end else begin
      glitch_d = glitch_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_count = glitch_q;
`else
  logic unused_glitch;
  assign unused_glitch = glitch_clr ^ abort[0] ^ abort[1];
  assign glitch_count  = '0;
`endif

endmodule

// File: tb/tb_sd_det_debounce.sv
// Directed bench for sd_det_debounce with DEBOUNCE_CYCLES=8, CNT_W=4.
// Glitch-counter expectations follow SD_DET_GLITCH_CNT_EN (zero when undefined).
module tb_sd_det_debounce;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] pin_in;
  logic [1:0] stable_out;
  logic [1:0] change_pulse;
  logic       card_present;
  logic       card_inserted;
  logic       card_removed;
  logic [7:0] glitch_count;
  logic       glitch_clr;

  int checks = 0;
  int errors = 0;

`ifdef SD_DET_GLITCH_CNT_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  sd_det_debounce #(
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (4),
    .RESET_VAL      (2'b11)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pin_in       (pin_in),
    .stable_out   (stable_out),
    .change_pulse (change_pulse),
    .card_present (card_present),
    .card_inserted(card_inserted),
    .card_removed (card_removed),
    .glitch_count (glitch_count),
    .glitch_clr   (glitch_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gexp(input int v);
    return GLITCH_EN ? 8'(v) : 8'd0;
  endfunction

  // Both pins bounce away from stable 2'b10 for two cycles; abort lands on the 5th edge.
  task automatic glitch_both(input logic clr_on_abort);
    pin_in = 2'b01;
    step(2);
    pin_in = 2'b10;
    step(2);
    glitch_clr = clr_on_abort;
    step(1);
    glitch_clr = 1'b0;
    step(1);
  endtask

  initial begin
    reset_n    = 1'b0;
    pin_in     = 2'b11;
    glitch_clr = 1'b0;
    step(3);
    check("rst_stable", 8'(stable_out), 8'h3);
    check("rst_present", 8'(card_present), 8'h0);
    check("rst_pulses", 8'({change_pulse, card_inserted, card_removed}), 8'h0);
    check("rst_glitch", glitch_count, 8'h0);

    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      check("idle_quiet", 8'({stable_out, change_pulse, card_inserted, card_removed}), 8'h30);
    end
    check("idle_present", 8'(card_present), 8'h0);

    // Clean CD step: stable_out[0] must fall on exactly the 10th edge.
    pin_in = 2'b10;
    for (int i = 1; i < 10; i++) begin
      step(1);
      check("ins_wait", 8'({stable_out, change_pulse}), 8'hc);
    end
    step(1);
    check("ins_stable", 8'(stable_out), 8'h2);
    check("ins_change", 8'(change_pulse), 8'h1);
    check("ins_evt", 8'({card_inserted, card_removed}), 8'h2);
    check("ins_present", 8'(card_present), 8'h1);
    step(1);
    check("ins_one_cycle", 8'({change_pulse, card_inserted, card_removed}), 8'h0);

    // 5-cycle and 7-cycle bounces (7 = DEBOUNCE_CYCLES-1) must never reach stable_out.
    pin_in = 2'b11;
    step(5);
    pin_in = 2'b10;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("glitch5_quiet", 8'({stable_out, change_pulse}), 8'h8);
    end
    check("glitch5_cnt", glitch_count, gexp(1));
    pin_in = 2'b11;
    step(7);
    pin_in = 2'b10;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("glitch7_quiet", 8'({stable_out, change_pulse}), 8'h8);
    end
    check("glitch7_cnt", glitch_count, gexp(2));

    // Removal.
    pin_in = 2'b11;
    for (int i = 1; i < 10; i++) begin
      step(1);
      check("rem_wait", 8'({stable_out, change_pulse}), 8'h8);
    end
    step(1);
    check("rem_stable", 8'(stable_out), 8'h3);
    check("rem_change", 8'(change_pulse), 8'h1);
    check("rem_evt", 8'({card_inserted, card_removed}), 8'h1);
    check("rem_present", 8'(card_present), 8'h0);
    step(1);
    check("rem_one_cycle", 8'({change_pulse, card_removed}), 8'h0);

    // Both bits step together.
    pin_in = 2'b00;
    for (int i = 1; i < 10; i++) begin
      step(1);
      check("both_wait", 8'({stable_out, change_pulse}), 8'hc);
    end
    step(1);
    check("both_stable", 8'(stable_out), 8'h0);
    check("both_change", 8'(change_pulse), 8'h3);
    check("both_evt", 8'({card_inserted, card_removed}), 8'h2);
    step(1);
    check("both_one_cycle", 8'({change_pulse, card_inserted}), 8'h0);

    pin_in = 2'b11;
    step(10);
    check("back_stable", 8'({stable_out, card_removed}), 8'h7);
    step(1);

    // Reset at count 5 of a CD qualification, pin held low across reset.
    pin_in = 2'b10;
    step(7);
    check("pre_rst_stable", 8'(stable_out), 8'h3);
    reset_n = 1'b0;
    #1;
    check("midrst_stable", 8'(stable_out), 8'h3);
    check("midrst_pulses", 8'({change_pulse, card_inserted, card_removed}), 8'h0);
    check("midrst_glitch", glitch_count, 8'h0);
    step(2);
    reset_n = 1'b1;
    for (int i = 1; i < 10; i++) begin
      step(1);
      check("rq_wait", 8'({stable_out, change_pulse, card_inserted}), 8'h18);
    end
    step(1);
    check("rq_stable", 8'(stable_out), 8'h2);
    check("rq_inserted", 8'({change_pulse, card_inserted}), 8'h3);
    step(1);
    check("rq_one_cycle", 8'({change_pulse, card_inserted}), 8'h0);

    // Glitch counter: +2 per dual abort, saturation, clear-wins, plain clear.
    glitch_both(1'b0);
    check("dual_abort", glitch_count, gexp(2));
    for (int i = 0; i < 130; i++) glitch_both(1'b0);
    check("glitch_sat", glitch_count, gexp(255));
    check("sat_stable", 8'({stable_out, change_pulse}), 8'h8);
    glitch_both(1'b1);
    check("clr_wins", glitch_count, 8'h0);
    glitch_both(1'b0);
    check("after_clr", glitch_count, gexp(2));
    glitch_clr = 1'b1;
    step(1);
    glitch_clr = 1'b0;
    check("plain_clr", glitch_count, 8'h0);
    step(1);
    check("final_stable", 8'({stable_out, card_present}), 8'h5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
